// File: rtl/generic_pack.sv
// Shared types and default geometry for the AXI4-Stream video ingress path.
package generic_pack;

    localparam int unsigned DEF_IMG_WIDTH  = 1920;
    localparam int unsigned DEF_IMG_HEIGHT = 1080;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } rx_state_e;

    // Sideband half of a FIFO entry; the top appends its own DATA_WIDTH tdata field.
    typedef struct packed {
        logic tuser;
        logic tlast;
    } vid_side_t;

endpackage

// File: rtl/axi4s_fwft_fifo.sv
// Generic first-word-fall-through FIFO with wrap-bit pointers and occupancy output.
module axi4s_fwft_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      fill_level_o
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push, pop;

    assign push = wr_en_i & ~full_o;
    assign pop  = rd_en_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign empty_o      = (wr_ptr_q == rd_ptr_q);
    assign full_o       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fill_level_o = wr_ptr_q - rd_ptr_q;
    // Storage is not reset, so mask the head entry to keep outputs zero while empty.
    assign rd_data_o    = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/axi4s_video_rx_sync_fifo.sv
// AXI4-Stream video ingress: FWFT buffering, SOF lock, line/frame geometry checking.
// Define AXI4S_DROP_UNSYNC_EN to discard beats that arrive before the first SOF.
module axi4s_video_rx_sync_fifo
    import generic_pack::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned CNT_WIDTH  = 12
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tuser,
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [CNT_WIDTH-1:0]          pixel_cnt,
    output logic [CNT_WIDTH-1:0]          line_cnt,
    output logic                          frame_done,
    output logic                          err_early_eol,
    output logic                          err_late_eol,
    output logic                          err_sof_mid,
    input  logic                          err_clr
);

    localparam logic [CNT_WIDTH-1:0] PIX_LAST  = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] LINE_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef struct packed {
        vid_side_t             side;
        logic [DATA_WIDTH-1:0] tdata;
    } fifo_entry_t;

    rx_state_e            state_q, state_d;
    logic                 ready_q;
    logic [CNT_WIDTH-1:0] pixel_cnt_q, pixel_cnt_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 err_early_q, err_early_d;
    logic                 err_late_q, err_late_d;
    logic                 err_sof_q, err_sof_d;

    logic                 accept, wr_en, fifo_full, fifo_empty;
    logic                 sync, eol, set_early, set_late, set_sof;
    logic [CNT_WIDTH-1:0] pix, line;
    fifo_entry_t          wr_entry, rd_entry;

    assign accept        = s_axis_tvalid & s_axis_tready;
    // ready_q holds tready low through reset and the first edge after release.
    assign s_axis_tready = ready_q & ~fifo_full;
    assign m_axis_tvalid = ~fifo_empty;

`ifdef AXI4S_DROP_UNSYNC_EN
    assign wr_en = accept & ((state_q == IN_FRAME) | s_axis_tuser);
`else
    assign wr_en = accept;
`endif

    assign wr_entry.side.tuser = s_axis_tuser;
    assign wr_entry.side.tlast = s_axis_tlast;
    assign wr_entry.tdata      = s_axis_tdata;

    axi4s_fwft_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (aclk),
        .rst_ni       (aresetn),
        .wr_en_i      (wr_en),
        .wr_data_i    (wr_entry),
        .rd_en_i      (m_axis_tready),
        .rd_data_o    (rd_entry),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .fill_level_o (fill_level)
    );

    assign m_axis_tdata = rd_entry.tdata;
    assign m_axis_tuser = rd_entry.side.tuser;
    assign m_axis_tlast = rd_entry.side.tlast;

    // An SOF beat is treated as pixel 0 of line 0, so the line-end checks apply to it too.
    always_comb begin
        state_d      = state_q;
        pixel_cnt_d  = pixel_cnt_q;
        line_cnt_d   = line_cnt_q;
        frame_done_d = 1'b0;
        sync         = 1'b0;
        eol          = 1'b0;
        set_early    = 1'b0;
        set_late     = 1'b0;
        set_sof      = 1'b0;
        pix          = pixel_cnt_q;
        line         = line_cnt_q;

        if (accept) begin
            if (s_axis_tuser) begin
                sync    = 1'b1;
                pix     = '0;
                line    = '0;
                set_sof = (state_q == IN_FRAME);
            end else if (state_q == IN_FRAME) begin
                sync = 1'b1;
            end
        end

        if (sync) begin
            eol       = s_axis_tlast | (pix == PIX_LAST);
            set_early = s_axis_tlast & (pix < PIX_LAST);
            set_late  = ~s_axis_tlast & (pix == PIX_LAST);
            state_d   = IN_FRAME;
            if (eol) begin
                pixel_cnt_d = '0;
                if (line == LINE_LAST) begin
                    line_cnt_d   = '0;
                    frame_done_d = 1'b1;
                    state_d      = WAIT_SOF;
                end else begin
                    line_cnt_d = line + CNT_ONE;
                end
            end else begin
                pixel_cnt_d = pix + CNT_ONE;
                line_cnt_d  = line;
            end
        end

        err_early_d = set_early | (err_early_q & ~err_clr);
        err_late_d  = set_late  | (err_late_q  & ~err_clr);
        err_sof_d   = set_sof   | (err_sof_q   & ~err_clr);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= WAIT_SOF;
            ready_q      <= 1'b0;
            pixel_cnt_q  <= '0;
            line_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            err_early_q  <= 1'b0;
            err_late_q   <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= 1'b1;
            pixel_cnt_q  <= pixel_cnt_d;
            line_cnt_q   <= line_cnt_d;
            frame_done_q <= frame_done_d;
            err_early_q  <= err_early_d;
            err_late_q   <= err_late_d;
            err_sof_q    <= err_sof_d;
        end
    end

    assign pixel_cnt     = pixel_cnt_q;
    assign line_cnt      = line_cnt_q;
    assign frame_done    = frame_done_q;
    assign err_early_eol = err_early_q;
    assign err_late_eol  = err_late_q;
    assign err_sof_mid   = err_sof_q;

endmodule

// File: doc/axi4s_video_rx_sync_fifo.md
Name: axi4s_video_rx_sync_fifo

Overview:
Parametrised AXI4-Stream video ingress stage that sits between the rx stream channel and the VFP pixel pipeline. It buffers beats in a first-word-fall-through FIFO of configurable width and depth. It locks to frame start (TUSER), counts pixels per line and lines per frame against the configured geometry, and reports framing errors. It generalises the previous fixed rx hookup with buffering, frame sync and line/frame checking.

Parameters:
DATA_WIDTH, 24, tdata width in bits (one pixel per beat).
FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
IMG_WIDTH, 1920, pixels per line.
IMG_HEIGHT, 1080, lines per frame.
CNT_WIDTH, 12, width of the pixel and line counters; must satisfy 2**CNT_WIDTH > max(IMG_WIDTH, IMG_HEIGHT).

Ports:
aclk  in  1  single clock for all logic
aresetn  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  rx beat valid
s_axis_tready  out  1  rx ready
s_axis_tdata  in  DATA_WIDTH  rx pixel
s_axis_tuser  in  1  start of frame (SOF)
s_axis_tlast  in  1  end of line (EOL)
m_axis_tvalid  out  1  tx beat valid
m_axis_tready  in  1  tx ready
m_axis_tdata  out  DATA_WIDTH  tx pixel
m_axis_tuser  out  1  SOF, forwarded
m_axis_tlast  out  1  EOL, forwarded
fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
pixel_cnt  out  CNT_WIDTH  input-side pixel index in the current line
line_cnt  out  CNT_WIDTH  input-side line index in the current frame
frame_done  out  1  one-cycle pulse on acceptance of the last EOL of a frame
err_early_eol  out  1  sticky: tlast seen before pixel IMG_WIDTH-1
err_late_eol  out  1  sticky: pixel IMG_WIDTH-1 seen without tlast
err_sof_mid  out  1  sticky: tuser seen inside a frame
err_clr  in  1  clears all sticky errors

Behaviour:
- Reset (asynchronous, aresetn=0): FIFO empty, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tuser/tlast=0, fill_level=0, counters=0, frame_done=0, all errors=0, FSM=WAIT_SOF. s_axis_tready rises on the first clock edge after deassertion.
- Reset mid-frame discards FIFO contents and any partial frame.
- Accept = s_axis_tvalid & s_axis_tready. Pop = m_axis_tvalid & m_axis_tready.
- s_axis_tready = !full. It is registered, so there is no push into a full FIFO even when a pop happens in the same cycle.
- m_axis_tvalid = !empty. The FIFO is first-word-fall-through: a beat written at edge N is presented at m_axis after edge N. Minimum latency is 1 cycle.
- Push and pop may occur in the same cycle when the FIFO is neither full nor empty; fill_level is unchanged in that case.
- Read and write pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the remaining bits are equal.
- FSM WAIT_SOF:
  - An accepted beat with tuser=1 is written, sets pixel_cnt=1 (or 0 and line_cnt+1 if tlast also set), sets line_cnt=0, and moves the FSM to IN_FRAME.
  - Accepted beats with tuser=0 are handled per the optional feature.
- FSM IN_FRAME, on each accepted beat:
  - tuser=1: set err_sof_mid, restart counters as a new SOF, write the beat.
  - tlast=1 with pixel_cnt<IMG_WIDTH-1: set err_early_eol, then end the line.
  - tlast=0 with pixel_cnt==IMG_WIDTH-1: set err_late_eol, force the line end internally. The forwarded tlast stays as received.
  - End of line: pixel_cnt=0, line_cnt+1. If line_cnt==IMG_HEIGHT-1, pulse frame_done the next cycle, set line_cnt=0 and return to WAIT_SOF.
- Errors are sticky until err_clr. If an error is set and err_clr is asserted in the same cycle, the set wins.

Optional Feature:
Macro AXI4S_DROP_UNSYNC_EN.
- Defined: beats accepted in WAIT_SOF with tuser=0 are consumed (tready honoured) but not written to the FIFO, so downstream only sees whole frames.
- Undefined: such beats are written and forwarded unchanged; counters and errors stay idle until SOF.

Decomposition:
- Package generic_pack gains the default geometry constants (IMG_WIDTH, IMG_HEIGHT), a typedef enum {WAIT_SOF, IN_FRAME} for the FSM, and a packed struct {tuser, tlast, tdata} for the FIFO entry.
- One sub-module, axi4s_fwft_fifo: generic FWFT FIFO with WIDTH and DEPTH parameters, exposing full, empty and fill_level.
- The FSM, counters and checker stay in the top module.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, m_axis_tready=1, one clean frame of 8 beats → 8 beats out in order, tlast on beats 4 and 8, frame_done pulses once, no errors.
- m_axis_tready=0 with 20 beats offered, FIFO_DEPTH=16 → s_axis_tready drops after 16 accepts and fill_level=16. Then tready=1 → all 16 drain in order, fill_level returns to 0.
- tlast on pixel 2 with IMG_WIDTH=4 → err_early_eol=1, line_cnt increments. Apply err_clr → error returns to 0.
- tuser asserted on pixel 3 of line 1 → err_sof_mid=1, line_cnt=0, pixel_cnt=1.
- 3 beats with tuser=0 before SOF → with AXI4S_DROP_UNSYNC_EN, 0 beats appear at output. Without the macro, all 3 are forwarded.
- aresetn pulsed low with fill_level=5 mid-frame → all outputs zero immediately, and the next frame passes cleanly.
